pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter CTRL_W, default 4, width of the control bundle (RegWrite/MemtoReg/MemWrite/Branch style flags).
REQ-002 SHALL have parameter DATA_W, default 32, width of one data word.
REQ-003 SHALL have parameter NUM_DATA, default 3, number of data words carried per entry.
REQ-004 SHALL have parameter REG_W, default 5, width of the destination-register field.
REQ-005 SHALL have parameter CNT_W, default 16, width of the transfer counter.
REQ-006 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-007 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port in_valid  input  1  upstream entry present.
REQ-009 SHALL have port in_ready  output  1  stage can accept an entry this cycle.
REQ-010 SHALL have port in_ctrl  input  CTRL_W  control bundle.
REQ-011 SHALL have port in_data  input  NUM_DATA*DATA_W  data words, word k at bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have port in_reg  input  REG_W  destination register.
REQ-013 SHALL have port out_valid  output  1  head entry present.
REQ-014 SHALL have port out_ready  input  1  downstream accepts head entry.
REQ-015 SHALL have port out_ctrl / out_data / out_reg  output  CTRL_W / NUM_DATA*DATA_W / REG_W  head entry fields.
REQ-016 SHALL have port stall  input  1  hazard hold; blocks popping regardless of out_ready.
REQ-017 SHALL have port flush  input  1  synchronous kill of all held entries.
REQ-018 SHALL have port occupancy  output  2  entries held (0..2).
REQ-019 SHALL have port xfer_count  output  CNT_W  count of entries popped since reset.

Function
REQ-020 SHALL hold two entries: main (head) and skid; states EMPTY (occ 0), ONE (main valid), TWO (main+skid valid).
REQ-021 SHALL define accept = in_valid & in_ready & !flush, and pop = out_valid & out_ready & !stall.
REQ-022 SHALL drive in_ready = (occ != 2) & !RST, decoded from state only; no combinational path from out_ready, stall or in_valid.
REQ-023 SHALL drive out_valid = (occ != 0); out_data/out_reg from main.
REQ-024 SHALL force out_ctrl to all-zero whenever out_valid is 0 (bubble), else main ctrl.
REQ-025 SHALL transition EMPTY: accept -> ONE, main <= input; else stay.
REQ-026 SHALL transition ONE: accept & pop -> ONE, main <= input; accept & !pop -> TWO, skid <= input; !accept & pop -> EMPTY; else hold.
REQ-027 SHALL transition TWO: pop -> ONE, main <= skid; else hold (no accept possible).
REQ-028 SHALL give latency of exactly 1 cycle from accept into EMPTY to out_valid high.
REQ-029 SHALL preserve entry order; no entry dropped or duplicated except by flush.
REQ-030 SHALL, on flush, go to EMPTY next edge, zero stored ctrl of both entries, discard any same-cycle input, and not count any same-cycle pop.
REQ-031 SHALL, while stall is high, hold all entries and fields unchanged, but still accept into free space per REQ-025/026 (pop=0).
REQ-032 SHALL increment xfer_count by 1 on each pop, wrapping from 2^CNT_W-1 to 0.
REQ-033 SHALL give flush priority over stall, accept and pop when simultaneous.
REQ-034 SHALL drive occupancy from the state register: EMPTY=0, ONE=1, TWO=2; value 3 never produced.

Reset
REQ-035 SHALL, on RST assertion, immediately set state EMPTY, all stored ctrl/data/reg to 0, xfer_count to 0; out_valid 0, out_ctrl 0, occupancy 0, in_ready 0.
REQ-036 SHALL abort any in-progress transfer on reset mid-operation; in_ready returns to 1 the first CLK edge period after RST deasserts.

Verification
REQ-037 SHALL cover: single entry ctrl=4'b1011, data={32'h3,32'h2,32'h1}, reg=5'd7 into EMPTY, out_ready=1 -> out_valid high next cycle with identical fields, xfer_count=1.
REQ-038 SHALL cover: out_ready=0, push A,B -> occupancy 2, in_ready 0; release out_ready -> A then B on consecutive cycles, occupancy 0, xfer_count=2.
REQ-039 SHALL cover: stall=1 with out_ready=1 and entry A held for 3 cycles -> out fields constant, xfer_count unchanged; stall=0 -> A popped once.
REQ-040 SHALL cover: occupancy 2 plus flush=1 with in_valid=1 -> next cycle occupancy 0, out_ctrl 0, input not captured, xfer_count unchanged.
REQ-041 SHALL cover: CNT_W=4, 17 back-to-back pops -> xfer_count sequence wraps 15 -> 0 -> 1.
REQ-042 SHALL cover: RST pulse mid-cycle while occupancy 2 -> outputs zero without clock edge; after release, new entry accepted with 1-cycle latency.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register (main + skid) with valid/ready handshake,
// hazard stall, synchronous flush and a running count of popped entries.
module pipe_stage_reg #(
  parameter int CTRL_W   = 4,
  parameter int DATA_W   = 32,
  parameter int NUM_DATA = 3,
  parameter int REG_W    = 5,
  parameter int CNT_W    = 16
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic [REG_W-1:0]           in_reg,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [REG_W-1:0]           out_reg,
  input  logic                       stall,
  input  logic                       flush,
  output logic [1:0]                 occupancy,
  output logic [CNT_W-1:0]           xfer_count
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [CTRL_W-1:0]          mainCtrl_q, mainCtrl_d, skidCtrl_q, skidCtrl_d;
  logic [NUM_DATA*DATA_W-1:0] mainData_q, mainData_d, skidData_q, skidData_d;
  logic [REG_W-1:0]           mainReg_q, mainReg_d, skidReg_q, skidReg_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       accept, pop;

  // Handshake outputs depend only on the state register, never on downstream inputs.
  assign in_ready   = (state_q != ST_TWO) & ~RST;
  assign out_valid  = (state_q != ST_EMPTY);
  assign out_ctrl   = out_valid ? mainCtrl_q : '0;
  assign out_data   = mainData_q;
  assign out_reg    = mainReg_q;
  assign xfer_count = cnt_q;

  always_comb begin
    occupancy = 2'd0;
    if (state_q == ST_ONE)      occupancy = 2'd1;
    else if (state_q == ST_TWO) occupancy = 2'd2;
  end

  assign accept = in_valid & in_ready & ~flush;
  assign pop    = out_valid & out_ready & ~stall;

  always_comb begin
    state_d    = state_q;
    mainCtrl_d = mainCtrl_q;
    mainData_d = mainData_q;
    mainReg_d  = mainReg_q;
    skidCtrl_d = skidCtrl_q;
    skidData_d = skidData_q;
    skidReg_d  = skidReg_q;
    cnt_d      = cnt_q;
    // Flush overrides everything, including a pop that would otherwise be counted.
    if (flush) begin
      state_d    = ST_EMPTY;
      mainCtrl_d = '0;
      skidCtrl_d = '0;
    end else begin
      if (pop) cnt_d = cnt_q + CNT_W'(1);
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d    = ST_ONE;
            mainCtrl_d = in_ctrl;
            mainData_d = in_data;
            mainReg_d  = in_reg;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            mainCtrl_d = in_ctrl;
            mainData_d = in_data;
            mainReg_d  = in_reg;
          end else if (accept) begin
            state_d    = ST_TWO;
            skidCtrl_d = in_ctrl;
            skidData_d = in_data;
            skidReg_d  = in_reg;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_d    = ST_ONE;
            mainCtrl_d = skidCtrl_q;
            mainData_d = skidData_q;
            mainReg_d  = skidReg_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_EMPTY;
      mainCtrl_q <= '0;
      mainData_q <= '0;
      mainReg_q  <= '0;
      skidCtrl_q <= '0;
      skidData_q <= '0;
      skidReg_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mainCtrl_q <= mainCtrl_d;
      mainData_q <= mainData_d;
      mainReg_q  <= mainReg_d;
      skidCtrl_q <= skidCtrl_d;
      skidData_q <= skidData_d;
      skidReg_q  <= skidReg_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a queue models the two held entries
// and the expected transfer count; outputs are compared mid-cycle.
module tb_pipe_stage_reg;

  localparam int CTRL_W = 4, DATA_W = 32, NUM_DATA = 3, REG_W = 5, CNT_W = 4;
  localparam int DW = NUM_DATA * DATA_W;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DW-1:0]     data;
    logic [REG_W-1:0]  rg;
  } entry_t;

  logic              CLK = 1'b0, RST = 1'b1;
  logic              in_valid = 1'b0, out_ready = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DW-1:0]     in_data = '0;
  logic [REG_W-1:0]  in_reg = '0;
  logic              in_ready, out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DW-1:0]     out_data;
  logic [REG_W-1:0]  out_reg;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  xfer_count;

  entry_t           sbQueue[$];
  logic [CNT_W-1:0] expCnt = '0;
  int               checks = 0, failures = 0;

  pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .NUM_DATA(NUM_DATA),
                   .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_reg(in_reg),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_data(out_data), .out_reg(out_reg), .stall(stall), .flush(flush),
    .occupancy(occupancy), .xfer_count(xfer_count)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Compares every output against the model, then advances the model by this cycle's inputs.
  task automatic applyStimulus(input logic iv, input logic [CTRL_W-1:0] c, input logic [DW-1:0] d,
                               input logic [REG_W-1:0] r, input logic ordy, input logic st,
                               input logic fl);
    entry_t e;
    logic   doAccept, doPop;
    @(negedge CLK);
    in_valid = iv; in_ctrl = c; in_data = d; in_reg = r;
    out_ready = ordy; stall = st; flush = fl;
    #1;
    checkOutput("occupancy", occupancy, sbQueue.size());
    checkOutput("in_ready", in_ready, sbQueue.size() != 2);
    checkOutput("out_valid", out_valid, sbQueue.size() != 0);
    checkOutput("xfer_count", xfer_count, expCnt);
    if (sbQueue.size() == 0) begin
      checkOutput("bubble_ctrl", out_ctrl, 0);
    end else begin
      checkOutput("out_ctrl", out_ctrl, sbQueue[0].ctrl);
      checkOutput("out_data", out_data, sbQueue[0].data);
      checkOutput("out_reg", out_reg, sbQueue[0].rg);
    end
    doAccept = iv && (sbQueue.size() < 2) && !fl;
    doPop    = (sbQueue.size() > 0) && ordy && !st && !fl;
    if (fl) begin
      sbQueue.delete();
    end else begin
      if (doPop) begin
        void'(sbQueue.pop_front());
        expCnt = expCnt + 1'b1;
      end
      if (doAccept) begin
        e.ctrl = c; e.data = d; e.rg = r;
        sbQueue.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b0, '0, '0, '0, ordy, 1'b0, 1'b0);
  endtask

  task automatic resetPulse();
    @(negedge CLK);
    in_valid = 1'b0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
    #1 RST = 1'b1;
    #1;
    checkOutput("rst_occupancy", occupancy, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_ctrl", out_ctrl, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_xfer_count", xfer_count, 0);
    #1 RST = 1'b0;
    sbQueue.delete();
    expCnt = '0;
  endtask

  logic [DW-1:0] dA, dB;

  initial begin
    #1;
    checkOutput("init_occupancy", occupancy, 0);
    checkOutput("init_out_valid", out_valid, 0);
    checkOutput("init_in_ready", in_ready, 0);
    checkOutput("init_out_ctrl", out_ctrl, 0);
    checkOutput("init_xfer_count", xfer_count, 0);
    #2 RST = 1'b0;

    // Single entry, pops on the cycle after acceptance.
    applyStimulus(1'b1, 4'b1011, {32'h3, 32'h2, 32'h1}, 5'd7, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    checkOutput("single_count", xfer_count, 1);

    // Fill both entries with the downstream blocked, then drain.
    dA = {32'hA2, 32'hA1, 32'hA0};
    dB = {32'hB2, 32'hB1, 32'hB0};
    applyStimulus(1'b1, 4'h5, dA, 5'd10, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h6, dB, 5'd11, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hF, '1, 5'd31, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    checkOutput("drain_count", xfer_count, 3);

    // Stall holds the head for three cycles even with out_ready high.
    applyStimulus(1'b1, 4'h9, {32'hC2, 32'hC1, 32'hC0}, 5'd3, 1'b0, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Stall still lets a new entry into free space.
    applyStimulus(1'b1, 4'h1, {32'hD2, 32'hD1, 32'hD0}, 5'd4, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'h2, {32'hE2, 32'hE1, 32'hE0}, 5'd5, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush while full with a valid input and out_ready high.
    applyStimulus(1'b1, 4'h3, dA, 5'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h4, dB, 5'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h7, {32'h11, 32'h22, 32'h33}, 5'd9, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Back-to-back push/pop for 17 pops; the 4-bit counter wraps.
    for (int i = 0; i < 18; i++)
      applyStimulus(1'b1, 4'(i), {32'(i), 32'(i * 3), 32'(i * 7)}, 5'(i), 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Asynchronous reset while full, then recovery with one-cycle latency.
    applyStimulus(1'b1, 4'hA, dA, 5'd12, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hB, dB, 5'd13, 1'b0, 1'b0, 1'b0);
    resetPulse();
    idle(1'b0);
    applyStimulus(1'b1, 4'hC, {32'h77, 32'h66, 32'h55}, 5'd14, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
